// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves word hits with zero stall; misses stall the pipeline while the FSM
// writes back a dirty victim and refills the line from block memory.
//
// Ports
//   clock, reset              clock, asynchronous active-low reset
//   cpu_ren / cpu_wen         word read / write request (both high = ignored)
//   cpu_addr, cpu_wdata       byte address (bits [1:0] ignored), write data
//   cpu_rdata, cpu_stall      read data on a read hit (else 0), pipeline stall
//   mem_ren / mem_ready       block read request / read data valid
//   mem_wen / mem_done        block write request / write complete
//   mem_block_address         block address for the current transfer
//   mem_din / mem_dout        block written to / returned by memory
//   hit_cnt, miss_cnt, wb_cnt wrapping 32-bit performance counters
//
// state  | meaning
// S_IDLE | lookup; hits served, a miss launches WB or RD
// S_WB   | writing the dirty victim back (mem_wen high)
// S_GAP  | one cycle with both memory requests low between WB and RD
// S_RD   | refilling the line (mem_ren high)
module dcache #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4,
  parameter int LINES       = 16,
  parameter int MEM_ADDR_W  = 10,
  parameter int ADDR_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cpu_ren,
  input  logic                          cpu_wen,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [WORD_W-1:0]             cpu_wdata,
  output logic [WORD_W-1:0]             cpu_rdata,
  output logic                          cpu_stall,
  output logic                          mem_ren,
  output logic                          mem_wen,
  output logic [MEM_ADDR_W-1:0]         mem_block_address,
  output logic [WORD_W*BLOCK_WORDS-1:0] mem_din,
  input  logic [WORD_W*BLOCK_WORDS-1:0] mem_dout,
  input  logic                          mem_ready,
  input  logic                          mem_done,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt,
  output logic [31:0]                   wb_cnt
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = MEM_ADDR_W - IDX_W;
  localparam int BLK_W = WORD_W * BLOCK_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_GAP, S_RD} state_t;

  state_t                 state_q;
  logic [LINES-1:0]       valid_q, dirty_q;
  logic [TAG_W-1:0]       tag_q  [LINES];
  logic [BLK_W-1:0]       data_q [LINES];
  logic [IDX_W-1:0]       miss_idx_q;
  logic [TAG_W-1:0]       miss_tag_q;
  logic [MEM_ADDR_W-1:0]  mem_addr_q;
  logic [BLK_W-1:0]       mem_din_q;
  logic [31:0]            hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic [OFF_W-1:0]       off;
  logic [MEM_ADDR_W-1:0]  ba;
  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [BLK_W-1:0]       line_blk;
  logic [WORD_W-1:0]      hit_word;
  logic                   req, hit;
  logic                   unused_addr;

  assign off = cpu_addr[2 +: OFF_W];
  assign ba  = cpu_addr[2+OFF_W +: MEM_ADDR_W];
  assign idx = ba[IDX_W-1:0];
  assign tag = ba[MEM_ADDR_W-1:IDX_W];
  assign unused_addr = ^{cpu_addr[ADDR_W-1:2+OFF_W+MEM_ADDR_W], cpu_addr[1:0]};

  // Gating with reset keeps stall, rdata and the hit counter quiet while held in reset.
  assign req      = reset & (cpu_ren ^ cpu_wen);
  assign hit      = req & (state_q == S_IDLE) & valid_q[idx] & (tag_q[idx] == tag);
  assign line_blk = data_q[idx];
  assign hit_word = line_blk[int'(off)*WORD_W +: WORD_W];

  assign cpu_rdata = (hit && cpu_ren) ? hit_word : '0;
  assign cpu_stall = req & ~hit;

  assign mem_ren           = (state_q == S_RD);
  assign mem_wen           = (state_q == S_WB);
  assign mem_block_address = mem_addr_q;
  assign mem_din           = mem_din_q;
  assign hit_cnt           = hit_cnt_q;
  assign miss_cnt          = miss_cnt_q;
  assign wb_cnt            = wb_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
            if (cpu_wen) dirty_q[idx] <= 1'b1;
          end else if (req) begin
            miss_cnt_q   <= miss_cnt_q + 32'd1;
            miss_idx_q   <= idx;
            miss_tag_q   <= tag;
            // The line is about to be replaced; it stays invalid until the refill lands.
            valid_q[idx] <= 1'b0;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q    <= S_WB;
              mem_addr_q <= {tag_q[idx], idx};
              mem_din_q  <= data_q[idx];
            end else begin
              state_q    <= S_RD;
              mem_addr_q <= ba;
            end
          end
        end
        S_WB: begin
          if (mem_done) begin
            wb_cnt_q   <= wb_cnt_q + 32'd1;
            state_q    <= S_GAP;
            mem_addr_q <= {miss_tag_q, miss_idx_q};
          end
        end
        S_GAP: state_q <= S_RD;
        S_RD: begin
          if (mem_ready) begin
            valid_q[miss_idx_q] <= 1'b1;
            dirty_q[miss_idx_q] <= 1'b0;
            state_q             <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage is not reset; the valid bits qualify it.
  always_ff @(posedge clock) begin
    if (hit && cpu_wen) begin
      data_q[idx][int'(off)*WORD_W +: WORD_W] <= cpu_wdata;
    end
    if (state_q == S_RD && mem_ready) begin
      data_q[miss_idx_q] <= mem_dout;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end
endmodule
